// File: rtl/telem_pkg.sv
// Shared types and helpers for the telemetry sequencer.
// Ring codes are used by both the per-channel gate rings and the bit-phase (DT) ring.
package telem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        SHIFT = 2'd2
    } telem_state_e;

    localparam logic [2:0] GT1 = 3'b001;
    localparam logic [2:0] GT2 = 3'b010;
    localparam logic [2:0] GT3 = 3'b100;

    // True when exactly one bit is set; callers zero-extend narrower vectors to 8 bits.
    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

endpackage

// File: rtl/telem_ring3.sv
// Three-phase one-hot ring: 001 -> 010 -> 100 -> 001 on each advance.
// 'init' forces the ring back to phase 1; any non-one-hot code self-recovers to 001.
module telem_ring3
    import telem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       adv,
    input  logic       init,
    output logic [2:0] q
);

    // Ring register with illegal-code recovery taking priority over advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= GT1;
        end else if (!is_onehot({5'd0, q}) || init) begin
            q <= GT1;
        end else if (adv) begin
            q <= {q[1:0], q[2]};
        end
    end

endmodule

// File: rtl/telem_seq_n.sv
// NCH-channel telemetry sequencer: synchronises TSYNC, issues TRP, accepts one
// word on LOAD and serialises it MSB first under the three-phase DT ring.
// Optional build macro: TELEM_PARITY_EN appends an odd-parity bit after bit 0.
//
// Handshake: there is no backpressure. SYNCP is honoured only in IDLE (and not in
// the TCW cycle); LOAD is honoured only in REQ with a one-hot DC; everything else
// is dropped, with a dropped sync recorded in the sticky OVR flag.
module telem_seq_n
    import telem_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int WIDTH       = 26,
    parameter int SYNC_STAGES = 2,
    parameter int TMO         = 64
) (
    input  logic               SIM_CLK,
    input  logic               SIM_RST,
    input  logic               TSYNC,
    input  logic               SYNC_EN,
    input  logic               BIT_STB,
    input  logic               LOAD,
    input  logic [NCH-1:0]     DC,
    input  logic [WIDTH-1:0]   DATA_IN,
    input  logic               CLR,
    output logic               TRP,
    output logic               TCW,
    output logic               DOUT,
    output logic [2:0]         DT,
    output logic [3*NCH-1:0]   GT,
    output logic               BUSY,
    output logic               OVR,
    output logic               TMOF,
    output logic [1:0]         state_dbg
);

    localparam int BCW = $clog2(WIDTH + 1);
    localparam int TW  = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

    telem_state_e      state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic              sync_prev_q;
    logic              syncp;
    logic [WIDTH-1:0]  sreg_q;
    logic [BCW-1:0]    bit_cnt_q;
    logic [TW-1:0]     tmo_cnt_q;
    logic [NCH-1:0]    chan_q;
    logic              trp_q, tcw_q, ovr_q, tmof_q;
    logic [2:0]        dt;
    logic [NCH-1:0]    gt_adv;
    logic              fill;
    logic              dc_ok;
    logic              go, accept, timeout, finish, shift_en, ovr_set;

`ifdef TELEM_PARITY_EN
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH);
    logic par_q;

    // Odd parity of the latched word, shifted in behind bit 0.
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) par_q <= 1'b0;
        else if (accept) par_q <= ~(^DATA_IN);
    end
    assign fill = par_q;
`else
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);
    assign fill = 1'b0;
`endif

    assign dc_ok = is_onehot(8'(DC));
    assign syncp = sync_q[SYNC_STAGES-1] & ~sync_prev_q & SYNC_EN;

    // TSYNC synchroniser chain plus rising-edge history.
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            sync_q      <= '0;
            sync_prev_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], TSYNC};
            sync_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // FSM state register.
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state and event decode; a sync in the TCW cycle counts as an overrun.
    always_comb begin
        state_d  = state_q;
        go       = 1'b0;
        accept   = 1'b0;
        timeout  = 1'b0;
        finish   = 1'b0;
        shift_en = (state_q == SHIFT) && BIT_STB && (dt == GT3);
        ovr_set  = syncp && ((state_q != IDLE) || tcw_q);
        case (state_q)
            IDLE: begin
                if (syncp && !tcw_q) begin
                    go      = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (LOAD && dc_ok) begin
                    accept  = 1'b1;
                    state_d = SHIFT;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (shift_en && (bit_cnt_q == LAST_BIT)) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: pulses, counters, shift register, channel latch and sticky flags.
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            trp_q     <= 1'b0;
            tcw_q     <= 1'b0;
            tmo_cnt_q <= '0;
            sreg_q    <= '0;
            bit_cnt_q <= '0;
            chan_q    <= '0;
            ovr_q     <= 1'b0;
            tmof_q    <= 1'b0;
        end else begin
            trp_q <= go;
            tcw_q <= finish;
            if (go) begin
                tmo_cnt_q <= '0;
            end else if ((state_q == REQ) && (tmo_cnt_q != '1)) begin
                tmo_cnt_q <= tmo_cnt_q + TW'(1);
            end
            if (accept) begin
                sreg_q    <= DATA_IN;
                bit_cnt_q <= '0;
                chan_q    <= DC;
            end else if (shift_en) begin
                sreg_q    <= {sreg_q[WIDTH-2:0], fill};
                bit_cnt_q <= bit_cnt_q + BCW'(1);
            end
            ovr_q  <= ovr_set | (ovr_q & ~CLR);
            tmof_q <= timeout | (tmof_q & ~CLR);
        end
    end

    telem_ring3 u_dt (
        .clk  (SIM_CLK),
        .rst  (SIM_RST),
        .adv  ((state_q == SHIFT) && BIT_STB),
        .init (accept),
        .q    (dt)
    );

    // Per-channel gate rings: GT3->GT1 on a new request, GT1->GT2 on load, GT2->GT3 on completion.
    for (genvar k = 0; k < NCH; k++) begin : g_gt
        logic [2:0] gt_k;
        assign gt_adv[k] = (go && (gt_k == GT3)) ||
                           (accept && DC[k] && (gt_k == GT1)) ||
                           (finish && chan_q[k] && (gt_k == GT2));
        telem_ring3 u_gt (
            .clk  (SIM_CLK),
            .rst  (SIM_RST),
            .adv  (gt_adv[k]),
            .init (1'b0),
            .q    (gt_k)
        );
        assign GT[3*k +: 3] = gt_k;
    end

    assign TRP       = trp_q;
    assign TCW       = tcw_q;
    assign DOUT      = (state_q == SHIFT) & sreg_q[WIDTH-1];
    assign DT        = dt;
    assign BUSY      = (state_q != IDLE);
    assign OVR       = ovr_q;
    assign TMOF      = tmof_q;
    assign state_dbg = state_q;

endmodule
